bus_master: RTL and testbench

Single-outstanding bus initiator for the memory-mapped peripheral bus. It accepts one CPU-side request at a time and drives the bus strobes and address into the shared address decoder. It waits for an acknowledge from the decoded device and returns read data, or an error for an unmapped address or a timeout. Sits between the core's load/store path and the decoder plus the seven device slots (DRAM, DROM, DMAT, DINT, DREG, DEXEC, DSPI; device IDs 0–6, ID 7 = no device).

---
 rtl/bus_master.sv | 166 ++++++++++++++++
 tb/tb_bus_master.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/bus_master.sv
// Single-outstanding bus initiator: one CPU request -> decoder/device strobes -> one response.
// Optional timeout counter is built only when BUS_MASTER_TIMEOUT_EN is defined.
module bus_master #(
  parameter int DATA_W  = 16,
  parameter int TIMEOUT = 15
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_we,
  input  logic [15:0]         req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_err,
  output logic [2:0]          rsp_did,
  output logic                bus_rd,
  output logic                bus_wr,
  output logic [15:0]         bus_addr,
  output logic [DATA_W-1:0]   bus_wdata,
  input  logic                dec_hit,
  input  logic [2:0]          dec_did,
  input  logic [6:0]          dev_ack,
  input  logic [7*DATA_W-1:0] dev_rdata,
  output logic [1:0]          dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid && ready are both 1;
  // valid and its payload stay stable until that edge.
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t              state, state_nx;
  logic                bus_rd_nx, bus_wr_nx;
  logic [15:0]         bus_addr_nx;
  logic [DATA_W-1:0]   bus_wdata_nx, rsp_rdata_nx;
  logic                rsp_err_nx;
  logic [2:0]          rsp_did_nx, did_q, did_nx;
  logic                sel_ack;
  logic [DATA_W-1:0]   sel_rdata;
  logic                expired;

`ifdef BUS_MASTER_TIMEOUT_EN
  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  logic [CW-1:0] cnt, cnt_nx;
  // cnt counts completed ack-less WAIT cycles; expiry is the TIMEOUT-th one
  assign expired = (cnt == CW'(TIMEOUT - 1));
`else
  assign expired = 1'b0;
`endif

  assign req_ready = (state == IDLE);
  assign rsp_valid = (state == RESP);
  assign dbg_state = state;

  // Only the device latched in ISSUE may complete the access
  always_comb begin
    sel_ack   = 1'b0;
    sel_rdata = '0;
    for (int n = 0; n < 7; n++) begin
      if (did_q == 3'(n)) begin
        sel_ack   = dev_ack[n];
        sel_rdata = dev_rdata[n*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    state_nx     = state;
    bus_rd_nx    = bus_rd;
    bus_wr_nx    = bus_wr;
    bus_addr_nx  = bus_addr;
    bus_wdata_nx = bus_wdata;
    rsp_rdata_nx = rsp_rdata;
    rsp_err_nx   = rsp_err;
    rsp_did_nx   = rsp_did;
    did_nx       = did_q;
`ifdef BUS_MASTER_TIMEOUT_EN
    cnt_nx       = cnt;
`endif
    case (state)
      IDLE: begin
        if (req_valid) begin
          bus_addr_nx = req_addr;
          bus_rd_nx   = !req_we;
          bus_wr_nx   = req_we;
          if (req_we) bus_wdata_nx = req_wdata;
          state_nx    = ISSUE;
        end
      end
      ISSUE: begin
        if (!dec_hit) begin
          bus_rd_nx    = 1'b0;
          bus_wr_nx    = 1'b0;
          rsp_err_nx   = 1'b1;
          rsp_did_nx   = 3'd7;
          rsp_rdata_nx = '0;
          state_nx     = RESP;
        end else begin
          did_nx   = dec_did;
`ifdef BUS_MASTER_TIMEOUT_EN
          cnt_nx   = '0;
`endif
          state_nx = WAIT;
        end
      end
      WAIT: begin
        if (sel_ack) begin
          bus_rd_nx    = 1'b0;
          bus_wr_nx    = 1'b0;
          rsp_rdata_nx = bus_wr ? '0 : sel_rdata;
          rsp_err_nx   = 1'b0;
          rsp_did_nx   = did_q;
          state_nx     = RESP;
        end else if (expired) begin
          bus_rd_nx    = 1'b0;
          bus_wr_nx    = 1'b0;
          rsp_rdata_nx = '0;
          rsp_err_nx   = 1'b1;
          rsp_did_nx   = did_q;
          state_nx     = RESP;
        end else begin
`ifdef BUS_MASTER_TIMEOUT_EN
          cnt_nx = cnt + 1'b1;
`endif
        end
      end
      RESP: begin
        if (rsp_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      bus_rd    <= 1'b0;
      bus_wr    <= 1'b0;
      bus_addr  <= '0;
      bus_wdata <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      rsp_did   <= 3'd7;
      did_q     <= 3'd7;
`ifdef BUS_MASTER_TIMEOUT_EN
      cnt       <= '0;
`endif
    end else begin
      state     <= state_nx;
      bus_rd    <= bus_rd_nx;
      bus_wr    <= bus_wr_nx;
      bus_addr  <= bus_addr_nx;
      bus_wdata <= bus_wdata_nx;
      rsp_rdata <= rsp_rdata_nx;
      rsp_err   <= rsp_err_nx;
      rsp_did   <= rsp_did_nx;
      did_q     <= did_nx;
`ifdef BUS_MASTER_TIMEOUT_EN
      cnt       <= cnt_nx;
`endif
    end
  end

endmodule

// File: tb/tb_bus_master.sv
// Bench for bus_master: decoder and device models, directed steps, then randomized accesses
// checked against a latency/response model derived from the address map and ack timing.
module tb_bus_master;

  localparam int DW = 16;
  localparam int TO = 15;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           req_valid = 1'b0, req_we = 1'b0, rsp_ready = 1'b0;
  logic [15:0]    req_addr = '0;
  logic [DW-1:0]  req_wdata = '0;
  logic           req_ready, rsp_valid, rsp_err, bus_rd, bus_wr, dec_hit;
  logic [DW-1:0]  rsp_rdata, bus_wdata;
  logic [2:0]     rsp_did, dec_did;
  logic [15:0]    bus_addr;
  logic [6:0]     dev_ack = '0;
  logic [7*DW-1:0] dev_rdata;
  logic [1:0]     dbg_state;

  logic [DW-1:0]  slice [7];
  logic [DW-1:0]  last_wdata = '0;
  int             checks = 0, failures = 0, cyc = 0;
  int             tgt = 7, ack_at = 1000, scnt = 0;

  bus_master #(.DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .rsp_did(rsp_did), .bus_rd(bus_rd), .bus_wr(bus_wr),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .dec_hit(dec_hit), .dec_did(dec_did),
    .dev_ack(dev_ack), .dev_rdata(dev_rdata), .dbg_state(dbg_state)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // decoder model: devices 0..6 at addr[15:12] = 0..6, anything else unmapped
  assign dec_hit = (bus_rd | bus_wr) && (bus_addr[15:12] < 4'd7);
  assign dec_did = dec_hit ? bus_addr[14:12] : 3'd7;

  always_comb begin
    dev_rdata = '0;
    for (int n = 0; n < 7; n++) dev_rdata[n*DW +: DW] = slice[n];
  end

  // device model: target acks on WAIT cycle ack_at; noise on other devices, and on all in ISSUE
  always @(negedge clk) begin
    logic [6:0] m;
    m = (tgt < 7) ? 7'(1 << tgt) : 7'd0;
    if (bus_rd | bus_wr) scnt = scnt + 1;
    else scnt = 0;
    if (scnt == 0) dev_ack = '0;
    else if (scnt == 1) dev_ack = 7'($urandom);
    else if (scnt == ack_at + 1) dev_ack = m;
    else dev_ack = (7'($urandom) | 7'h01) & ~m;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // reference: response and latency (cycles from accept edge to first rsp_valid cycle)
  task automatic model(input logic we, input logic [15:0] addr, input int ackk,
                       output int lat, output logic err, output logic [2:0] did,
                       output logic [DW-1:0] rd);
    bit timeout_en;
`ifdef BUS_MASTER_TIMEOUT_EN
    timeout_en = 1;
`else
    timeout_en = 0;
`endif
    if (addr[15:12] >= 4'd7) begin
      lat = 2; err = 1'b1; did = 3'd7; rd = '0;
    end else if (timeout_en && ackk > TO) begin
      lat = TO + 2; err = 1'b1; did = addr[14:12]; rd = '0;
    end else begin
      lat = 2 + ackk; err = 1'b0; did = addr[14:12];
      rd = we ? '0 : slice[addr[14:12]];
    end
  endtask

  task automatic run_txn(input logic we, input logic [15:0] addr, input logic [DW-1:0] wdata,
                         input int ackk, input int hold, input bit early_req);
    int lat, t0, e_lat;
    logic e_err;
    logic [2:0] e_did;
    logic [DW-1:0] e_rd;
    model(we, addr, ackk, e_lat, e_err, e_did, e_rd);
    tgt = (addr[15:12] < 4'd7) ? int'(addr[14:12]) : 7;
    ack_at = ackk;
    if (we) last_wdata = wdata;
    @(negedge clk);
    chk("req_ready_idle", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata;
    @(negedge clk);
    req_valid = 1'b0;
    t0 = cyc - 1;
    chk("issue_rd", 32'(bus_rd), 32'(!we));
    chk("issue_wr", 32'(bus_wr), 32'(we));
    chk("issue_addr", 32'(bus_addr), 32'(addr));
    chk("issue_wdata", 32'(bus_wdata), 32'(last_wdata));
    chk("issue_req_ready", 32'(req_ready), 32'd0);
    lat = 1;
    while (!rsp_valid && lat < 100) begin
      @(negedge clk);
      lat = cyc - t0;
      if (!rsp_valid) chk("wait_no_strobe_clash", 32'(bus_rd & bus_wr), 32'd0);
    end
    if (!rsp_valid) begin
      chk("rsp_wait_bound", 32'd0, 32'd1);
    end else begin
      chk("rsp_latency", 32'(lat), 32'(e_lat));
      chk("rsp_err", 32'(rsp_err), 32'(e_err));
      chk("rsp_did", 32'(rsp_did), 32'(e_did));
      chk("rsp_rdata", 32'(rsp_rdata), 32'(e_rd));
      chk("resp_strobes", 32'({bus_rd, bus_wr}), 32'd0);
      for (int i = 0; i < hold; i++) begin
        if (early_req) begin
          req_valid = 1'b1; req_we = 1'b0; req_addr = 16'h3000;
        end
        @(negedge clk);
        chk("hold_valid", 32'(rsp_valid), 32'd1);
        chk("hold_resp", {rsp_rdata, 12'd0, rsp_err, rsp_did}, {e_rd, 12'd0, e_err, e_did});
        chk("hold_req_ready", 32'(req_ready), 32'd0);
        chk("hold_strobes", 32'({bus_rd, bus_wr}), 32'd0);
      end
      req_valid = 1'b0;
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      chk("post_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("post_req_ready", 32'(req_ready), 32'd1);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_req_ready"}, 32'(req_ready), 32'd1);
    chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
    chk({tag, "_rsp"}, {rsp_rdata, 12'd0, rsp_err, rsp_did}, {16'd0, 12'd0, 1'b0, 3'd7});
    chk({tag, "_strobes"}, 32'({bus_rd, bus_wr}), 32'd0);
    chk({tag, "_bus_addr"}, 32'(bus_addr), 32'd0);
    chk({tag, "_bus_wdata"}, 32'(bus_wdata), 32'd0);
  endtask

  initial begin
    for (int n = 0; n < 7; n++) slice[n] = DW'($urandom);
    // reset
    repeat (3) @(posedge clk);
    #1 chk_reset_vals("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // directed steps
    slice[1] = 16'hBEEF;
    run_txn(1'b0, 16'h1ABC, 16'h0000, 2, 0, 0);
    run_txn(1'b1, 16'h6FFF, 16'h1234, 1, 0, 0);
    run_txn(1'b0, 16'h7000, 16'h0000, 1, 1, 0);
    slice[2] = 16'h00AA;
    run_txn(1'b0, 16'h2000, 16'h0000, 39, 0, 0);
    run_txn(1'b0, 16'h3004, 16'h0000, TO, 0, 0);
    run_txn(1'b1, 16'h5010, 16'hC3C3, TO + 1, 0, 0);
    slice[2] = 16'h5A5A;
    run_txn(1'b0, 16'h2000, 16'h0000, 3, 5, 1);

    // randomized accesses
    for (int k = 0; k < 24; k++) begin
      logic [15:0] a;
      int ackk;
      for (int n = 0; n < 7; n++) slice[n] = DW'($urandom);
      a = 16'($urandom);
      if ($urandom_range(0, 3) != 0) a[15] = 1'b0;
      ackk = ($urandom_range(0, 4) == 0) ? $urandom_range(TO - 1, TO + 3) : $urandom_range(1, 6);
      run_txn(1'($urandom), a, DW'($urandom), ackk, $urandom_range(0, 3), 1'($urandom));
    end

    // asynchronous reset in the middle of WAIT
    tgt = 4; ack_at = 1000;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 16'h4321; req_wdata = 16'h7777;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    chk("pre_reset_in_wait", 32'(bus_wr), 32'd1);
    #2 rst_n = 1'b0;
    #1 chk_reset_vals("async_reset");
    last_wdata = '0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("after_reset_idle", {30'd0, rsp_valid, req_ready}, 32'd1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
